sobel_pixel_feeder: RTL
=======================

// Module: sobel_pixel_feeder
// PURPOSE
//  Source end of the gray-pixel input interface of sobel_control. Walks a
//  WIDTH x HEIGHT gray frame in raster order and reads it from a synchronous
//  frame memory with 1-cycle read latency. Each pixel is presented on
//  input_px_gray/ack_read using a valid/ready handshake against req_read from
//  the consumer. A 2-entry prefetch (output reg + skid reg) sustains 1 px/cycle.
// PARAMETERS
//  WIDTH   320  pixels per line
//  HEIGHT  240  lines per frame
//  PX_W    15   gray pixel width (bits)
//  ADDR_W  17   memory address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
// PORTS
//  sobel_clk      in   1       single clock, all logic on rising edge
//  reset          in   1       asynchronous, active-low reset
//  start          in   1       1-cycle pulse, begin frame (ignored while busy)
//  mem_rd_en      out  1       memory read strobe
//  mem_addr       out  ADDR_W  read address, valid with mem_rd_en
//  mem_rd_data    in   PX_W    read data, valid the cycle after mem_rd_en
//  req_read       in   1       consumer ready for a pixel
//  ack_read       out  1       input_px_gray holds a valid pixel
//  input_px_gray  out  PX_W    pixel to consumer
//  px_col         out  9       column of the presented pixel
//  px_row         out  8       row of the presented pixel
//  busy           out  1       frame in progress
//  frame_done     out  1       1-cycle pulse after the last pixel transfer
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, FSM=IDLE, rd/wr counters 0, buffers empty.
//  Transfer: happens in the cycle where ack_read=1 and req_read=1.
//   - With ack_read=1 and no transfer, input_px_gray, px_col and px_row hold stable.
//   - ack_read never drops without a transfer.
//  FSM:
//   IDLE   -> RUN on start; rd_addr=0, busy=1.
//   RUN    issues reads, fills buffers, presents pixels.
//          -> DONE when the transfer of pixel WIDTH*HEIGHT-1 occurs.
//   DONE   frame_done=1 for exactly one cycle, busy=0 -> IDLE.
//  Read issue in cycle t requires all of:
//   - rd_addr < WIDTH*HEIGHT;
//   - (occupied entries + in-flight read - transfer in t) < 2.
//   mem_addr=rd_addr; rd_addr increments per issued read.
//  Data return:
//   - goes to the output reg if it is empty or drained this cycle and the skid
//     reg is empty; otherwise to the skid reg.
//   - the skid reg moves to the output reg on transfer; order strictly preserved.
//  Latency:
//   - start at edge 0 -> mem_rd_en at cycle 1 -> ack_read=1 at cycle 2.
//   - With req_read held 1: one pixel per cycle, no bubbles, WIDTH*HEIGHT transfers.
//  Position counters:
//   - px_col/px_row track the pixel in the output reg.
//   - px_col wraps WIDTH-1 -> 0 with px_row+1.
//   - Both counters cleared to 0 at start.
//  Boundaries:
//   - start while busy: ignored.
//   - start in the DONE cycle: ignored.
//   - req_read=1 while ack_read=0: no effect.
//   - Last pixel: no read beyond WIDTH*HEIGHT-1; ack_read=0 the cycle after its transfer.
//   - Reset mid-frame: immediate clear; in-flight read data discarded; the next
//     start restarts at address 0.
//   - Widths: px_col/px_row zero-extended from their counters; address compare is
//     unsigned ADDR_W bits.
// TESTING  (WIDTH=4, HEIGHT=2 unless noted; mem[i]=i+15'h100)
//  1 Reset: hold reset=0 -> ack_read=0, busy=0, mem_rd_en=0, frame_done=0, outputs=0.
//  2 Full frame, req_read=1: start at cycle 0
//     -> ack_read=1 from cycle 2; data 0x100..0x107 on consecutive cycles;
//        frame_done=1 at cycle 10 only.
//  3 Backpressure: req_read=0 for 5 cycles after the 3rd transfer
//     -> 0x103 held stable; exactly 2 reads issued ahead;
//        no loss or duplicate, 8 total transfers.
//  4 Position wrap: pixel 3 -> (col=3,row=0); pixel 4 -> (col=0,row=1).
//  5 start pulsed at cycle 4 mid-frame -> ignored; sequence identical to test 2.
//  6 reset=0 at cycle 5, released at cycle 7, start at cycle 9
//     -> outputs 0 during reset; first pixel 0x100 at cycle 11;
//        full frame delivered.

Source files
------------

// File: rtl/sobel_pixel_feeder_if.sv
// Pixel feeder bus: frame-memory read port plus the gray-pixel
// valid/ready handshake towards sobel_control.
interface sobel_pixel_feeder_if #(
  parameter int PX_W   = 15,
  parameter int ADDR_W = 17
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PX_W-1:0]   mem_rd_data;
  logic              req_read;
  logic              ack_read;
  logic [PX_W-1:0]   input_px_gray;
  logic [8:0]        px_col;
  logic [7:0]        px_row;

  modport master (
    output mem_rd_en,
    output mem_addr,
    input  mem_rd_data,
    input  req_read,
    output ack_read,
    output input_px_gray,
    output px_col,
    output px_row
  );

  modport slave (
    input  mem_rd_en,
    input  mem_addr,
    output mem_rd_data,
    output req_read,
    input  ack_read,
    input  input_px_gray,
    input  px_col,
    input  px_row
  );
endinterface

// File: rtl/sobel_pixel_feeder.sv
// Raster-order gray frame reader: 1-cycle sync memory feeding a
// 2-entry (output + skid) prefetch for 1 px/cycle delivery.
module sobel_pixel_feeder #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int PX_W   = 15,
  parameter int ADDR_W = 17
) (
  input  logic sobel_clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic frame_done,
  sobel_pixel_feeder_if.master bus
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(WIDTH * HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
  logic              infl_q, infl_d;
  logic              out_vld_q, out_vld_d;
  logic [PX_W-1:0]   out_q, out_d;
  logic              skid_vld_q, skid_vld_d;
  logic [PX_W-1:0]   skid_q, skid_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;

  logic       xfer;
  logic       last;
  logic       issue;
  logic [2:0] occ;

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    col_d      = col_q;
    row_d      = row_q;

    xfer = out_vld_q & bus.req_read;
    last = (col_q == COL_LAST) && (row_q == ROW_LAST);
    occ  = 3'(out_vld_q) + 3'(skid_vld_q) + 3'(infl_q) - 3'(xfer);
    issue = (state_q == RUN) && (rd_addr_q < NPIX) && (occ < 3'd2);

    infl_d = issue;
    if (issue) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end

    // Drain first so returning data sees the post-transfer occupancy.
    if (xfer) begin
      out_vld_d  = skid_vld_q;
      out_d      = skid_vld_q ? skid_q : out_q;
      skid_vld_d = 1'b0;
      if (!last) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end

    if (infl_q) begin
      if (!out_vld_d) begin
        out_d     = bus.mem_rd_data;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = bus.mem_rd_data;
        skid_vld_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          rd_addr_d = '0;
          col_d     = '0;
          row_d     = '0;
        end
      end
      RUN: begin
        if (xfer && last) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sobel_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      infl_q     <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      infl_q     <= infl_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign bus.mem_rd_en     = issue;
  assign bus.mem_addr      = rd_addr_q[ADDR_W-1:0];
  assign bus.ack_read      = out_vld_q;
  assign bus.input_px_gray = out_q;
  assign bus.px_col        = 9'(col_q);
  assign bus.px_row        = 8'(row_q);
  assign busy              = (state_q == RUN);
  assign frame_done        = (state_q == DONE);

endmodule
